// File: rtl/board_history_ctrl.sv
// Snapshot sequencer between the live 64-square board RAM and the history RAM:
// arbitrates commit/rewind/load/save requests and streams one square per cycle.
module board_history_ctrl #(
    parameter int SQ_W  = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            Clk,
    input  logic            reset_n,
    input  logic            req_commit,
    input  logic            req_rewind,
    input  logic            req_load,
    input  logic            req_save,
    output logic            ack_commit,
    output logic            ack_rewind,
    output logic            ack_load,
    output logic            ack_save,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AW:0]     hist_count,
    output logic            save_valid,
    output logic [5:0]      brd_addr,
    input  logic [SQ_W-1:0] brd_rd_data,
    output logic            brd_wr_en,
    output logic [SQ_W-1:0] brd_wr_data,
    output logic [AW+6:0]   hist_addr,
    input  logic [SQ_W-1:0] hist_rd_data,
    output logic            hist_wr_en,
    output logic [SQ_W-1:0] hist_wr_data
);

    typedef enum logic [1:0] {IDLE, COPY_OUT, COPY_IN, FINISH} state_t;
    typedef enum logic [1:0] {OP_COMMIT, OP_REWIND, OP_LOAD, OP_SAVE} op_t;

    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   HIST_FULL = {1'b1, {AW{1'b0}}};

    state_t        state;
    op_t           op;
    logic [6:0]    sq_idx_p0;
    logic          save_sel;
    logic [AW-1:0] slot;
    logic [AW-1:0] wr_ptr;

    logic          can_arb;
    logic          grant_vld;
    op_t           grant_op;
    logic          grant_refused;
    logic          grant_sel;
    logic [AW-1:0] grant_slot;

    function automatic logic [AW+6:0] hist_sq_addr(input logic sel, input logic [AW-1:0] slot_i,
                                                   input logic [5:0] sq);
        return {sel, slot_i, sq};
    endfunction

    // An ack cycle blinds the arbiter so a requester still holding its level is not re-granted.
    always_comb begin
        can_arb       = (state == IDLE || state == FINISH) &&
                        !(ack_commit | ack_rewind | ack_load | ack_save);
        grant_vld     = 1'b0;
        grant_op      = OP_COMMIT;
        if (can_arb) begin
            if (req_commit) begin
                grant_vld = 1'b1;
                grant_op  = OP_COMMIT;
            end else if (req_rewind) begin
                grant_vld = 1'b1;
                grant_op  = OP_REWIND;
            end else if (req_load) begin
                grant_vld = 1'b1;
                grant_op  = OP_LOAD;
            end else if (req_save) begin
                grant_vld = 1'b1;
                grant_op  = OP_SAVE;
            end
        end
        grant_refused = (grant_op == OP_REWIND && hist_count == '0) ||
                        (grant_op == OP_LOAD && !save_valid);
        grant_sel     = (grant_op == OP_LOAD || grant_op == OP_SAVE);
        grant_slot    = '0;
        if (grant_op == OP_COMMIT) begin
            grant_slot = wr_ptr;
        end else if (grant_op == OP_REWIND) begin
            grant_slot = wr_ptr - PTR_ONE;
        end
    end

    // Write data is the source RAM's read data, landing one cycle behind its address.
    assign brd_wr_data  = brd_wr_en  ? hist_rd_data : '0;
    assign hist_wr_data = hist_wr_en ? brd_rd_data  : '0;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= OP_COMMIT;
            sq_idx_p0  <= '0;
            save_sel   <= 1'b0;
            slot       <= '0;
            wr_ptr     <= '0;
            hist_count <= '0;
            save_valid <= 1'b0;
            ack_commit <= 1'b0;
            ack_rewind <= 1'b0;
            ack_load   <= 1'b0;
            ack_save   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            brd_addr   <= '0;
            brd_wr_en  <= 1'b0;
            hist_addr  <= '0;
            hist_wr_en <= 1'b0;
        end else begin
            ack_commit <= 1'b0;
            ack_rewind <= 1'b0;
            ack_load   <= 1'b0;
            ack_save   <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (grant_vld) begin
                        unique case (grant_op)
                            OP_COMMIT: ack_commit <= 1'b1;
                            OP_REWIND: ack_rewind <= 1'b1;
                            OP_LOAD:   ack_load   <= 1'b1;
                            OP_SAVE:   ack_save   <= 1'b1;
                        endcase
                        if (grant_refused) begin
                            err <= 1'b1;
                        end else begin
                            op        <= grant_op;
                            save_sel  <= grant_sel;
                            slot      <= grant_slot;
                            busy      <= 1'b1;
                            sq_idx_p0 <= '0;
                            if (grant_op == OP_COMMIT || grant_op == OP_SAVE) begin
                                state    <= COPY_OUT;
                                brd_addr <= '0;
                            end else begin
                                state     <= COPY_IN;
                                hist_addr <= hist_sq_addr(grant_sel, grant_slot, 6'd0);
                            end
                        end
                    end
                end
                COPY_OUT, COPY_IN: begin
                    if (sq_idx_p0 == 7'd64) begin
                        state      <= FINISH;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        brd_wr_en  <= 1'b0;
                        hist_wr_en <= 1'b0;
                        unique case (op)
                            OP_COMMIT: begin
                                wr_ptr <= wr_ptr + PTR_ONE;
                                if (hist_count != HIST_FULL) begin
                                    hist_count <= hist_count + CNT_ONE;
                                end
                            end
                            OP_REWIND: begin
                                wr_ptr     <= wr_ptr - PTR_ONE;
                                hist_count <= hist_count - CNT_ONE;
                            end
                            OP_LOAD:   hist_count <= '0;
                            OP_SAVE:   save_valid <= 1'b1;
                        endcase
                    end else begin
                        // read stage p0 addresses square sq_idx_p0+1; write stage lands square sq_idx_p0
                        sq_idx_p0 <= sq_idx_p0 + 7'd1;
                        if (state == COPY_OUT) begin
                            if (sq_idx_p0 != 7'd63) begin
                                brd_addr <= sq_idx_p0[5:0] + 6'd1;
                            end
                            hist_wr_en <= 1'b1;
                            hist_addr  <= hist_sq_addr(save_sel, slot, sq_idx_p0[5:0]);
                        end else begin
                            if (sq_idx_p0 != 7'd63) begin
                                hist_addr <= hist_sq_addr(save_sel, slot, sq_idx_p0[5:0] + 6'd1);
                            end
                            brd_wr_en <= 1'b1;
                            brd_addr  <= sq_idx_p0[5:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_history_ctrl.sv
// Bench for board_history_ctrl: RAM models, a queue-based history model checked every
// cycle, directed scenarios with literal expectations, then randomized request mixes.
module tb_board_history_ctrl;
    localparam int SQ_W  = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_commit = 1'b0, req_rewind = 1'b0, req_load = 1'b0, req_save = 1'b0;
    logic ack_commit, ack_rewind, ack_load, ack_save, busy, done, err, save_valid;
    logic [AW:0] hist_count;
    logic [5:0] brd_addr;
    logic [SQ_W-1:0] brd_rd_data, brd_wr_data, hist_rd_data, hist_wr_data;
    logic brd_wr_en, hist_wr_en;
    logic [AW+6:0] hist_addr;

    board_history_ctrl #(.SQ_W(SQ_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .reset_n(reset_n),
        .req_commit(req_commit), .req_rewind(req_rewind), .req_load(req_load), .req_save(req_save),
        .ack_commit(ack_commit), .ack_rewind(ack_rewind), .ack_load(ack_load), .ack_save(ack_save),
        .busy(busy), .done(done), .err(err), .hist_count(hist_count), .save_valid(save_valid),
        .brd_addr(brd_addr), .brd_rd_data(brd_rd_data), .brd_wr_en(brd_wr_en),
        .brd_wr_data(brd_wr_data), .hist_addr(hist_addr), .hist_rd_data(hist_rd_data),
        .hist_wr_en(hist_wr_en), .hist_wr_data(hist_wr_data)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM models with one cycle of read latency, plus a backdoor board loader.
    logic [3:0] board_mem [64];
    logic [3:0] hist_mem [2048];
    logic [3:0] brd_rd_q, hist_rd_q;
    logic bd_load = 1'b0;
    logic [255:0] bd_pat = '0;
    int n_brd_wr = 0, n_hist_wr = 0;
    always @(posedge Clk) begin
        if (bd_load) begin
            for (int i = 0; i < 64; i++) board_mem[i] <= bd_pat[i*4 +: 4];
        end else if (brd_wr_en) begin
            board_mem[brd_addr] <= brd_wr_data;
        end
        if (hist_wr_en) hist_mem[hist_addr] <= hist_wr_data;
        if (brd_wr_en) n_brd_wr <= n_brd_wr + 1;
        if (hist_wr_en) n_hist_wr <= n_hist_wr + 1;
        brd_rd_q  <= board_mem[brd_addr];
        hist_rd_q <= hist_mem[hist_addr];
    end
    assign brd_rd_data  = brd_rd_q;
    assign hist_rd_data = hist_rd_q;

    int tests = 0, fails = 0;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int hidx(input bit sel, input int slot, input int sq);
        return (sel ? 1024 : 0) + slot * 64 + sq;
    endfunction

    function automatic logic [255:0] brd_snap();
        logic [255:0] r;
        for (int i = 0; i < 64; i++) r[i*4 +: 4] = board_mem[i];
        return r;
    endfunction

    function automatic logic [255:0] hist_snap(input bit sel, input int slot);
        logic [255:0] r;
        for (int i = 0; i < 64; i++) r[i*4 +: 4] = hist_mem[hidx(sel, slot, i)];
        return r;
    endfunction

    function automatic logic [255:0] rand_pat();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: op_t is the cycle number within the current copy (0 = nothing running).
    // Ops: 0 commit, 1 rewind, 2 load, 3 save. History ring kept as a queue of snapshots.
    int op_t = 0, m_op = 0, mw = -1, m_ptr = 0, acc_slot = 0, wb0 = 0, wh0 = 0;
    bit blind = 1'b0, m_sv = 1'b0, acc_sel = 1'b0, e_err = 1'b0;
    logic [3:0] e_ackv = '0;
    logic [255:0] ring [$];
    logic [255:0] save_snap = '0, acc_snap = '0, chk_snap = '0;

    task automatic finish_op();
        case (m_op)
            0: begin
                chk_snap = acc_snap;
                ring.push_back(acc_snap);
                if (ring.size() > DEPTH) void'(ring.pop_front());
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            1: begin
                chk_snap = ring.pop_back();
                m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
            end
            2: begin
                chk_snap = save_snap;
                ring.delete();
            end
            default: begin
                save_snap = acc_snap;
                chk_snap = acc_snap;
                m_sv = 1'b1;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge Clk or negedge reset_n);
            if (!reset_n) begin
                op_t = 0; blind = 1'b0; e_ackv = '0; e_err = 1'b0;
                ring.delete(); m_ptr = 0; m_sv = 1'b0;
            end else begin
                e_ackv = '0; e_err = 1'b0;
                if (op_t >= 1 && op_t <= 64) begin
                    op_t++;
                end else if (op_t == 65) begin
                    op_t = 66;
                    finish_op();
                end else begin
                    op_t = 0; mw = -1;
                    if (!blind) begin
                        if (req_commit) mw = 0;
                        else if (req_rewind) mw = 1;
                        else if (req_load) mw = 2;
                        else if (req_save) mw = 3;
                    end
                    if (mw >= 0) begin
                        e_ackv[3-mw] = 1'b1;
                        if ((mw == 1 && ring.size() == 0) || (mw == 2 && !m_sv)) begin
                            e_err = 1'b1;
                        end else begin
                            m_op = mw; op_t = 1;
                            acc_snap = brd_snap(); wb0 = n_brd_wr; wh0 = n_hist_wr;
                            acc_sel = (mw >= 2);
                            acc_slot = (mw == 0) ? m_ptr : (mw == 1) ? (m_ptr + DEPTH - 1) % DEPTH : 0;
                        end
                    end
                end
                blind = (e_ackv != 0);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        int src, dst;
        bit out_dir, e_busy, e_done;
        forever begin
            @(negedge Clk);
            out_dir = (m_op == 0 || m_op == 3);
            e_busy  = (op_t >= 1 && op_t <= 65);
            e_done  = (op_t == 66);
            check("ctrl{acks,err,busy,done,bwe,hwe}",
                  {ack_commit, ack_rewind, ack_load, ack_save, err, busy, done, brd_wr_en, hist_wr_en},
                  {e_ackv, e_err, e_busy, e_done,
                   e_busy && op_t >= 2 && !out_dir, e_busy && op_t >= 2 && out_dir});
            check("hist_count", hist_count, ring.size());
            check("save_valid", save_valid, m_sv);
            if (e_busy) begin
                src = (op_t - 1 > 63) ? 63 : op_t - 1;
                dst = op_t - 2;
                if (out_dir) begin
                    check("brd_rd_addr", brd_addr, src);
                    if (op_t >= 2) check("hist_wr_addr", hist_addr, hidx(acc_sel, acc_slot, dst));
                end else begin
                    check("hist_rd_addr", hist_addr, hidx(acc_sel, acc_slot, src));
                    if (op_t >= 2) check("brd_wr_addr", brd_addr, dst);
                end
            end
            if (e_done) begin
                if (out_dir) begin
                    check("hist_contents", hist_snap(acc_sel, acc_slot), chk_snap);
                    check("hist_writes", n_hist_wr - wh0, 64);
                    check("brd_writes", n_brd_wr - wb0, 0);
                end else begin
                    check("board_contents", brd_snap(), chk_snap);
                    check("brd_writes", n_brd_wr - wb0, 64);
                    check("hist_writes", n_hist_wr - wh0, 0);
                end
            end
        end
    end

    int r_ack_cyc [4];
    int r_done_cyc;
    bit r_err, r_busy;

    task automatic load_board(input logic [255:0] p);
        bd_pat = p; bd_load = 1'b1;
        @(posedge Clk); #1;
        bd_load = 1'b0;
    endtask

    // m = {commit, rewind, load, save}; each request is held until its own ack, then dropped.
    task automatic run_reqs(input logic [3:0] m);
        int k;
        logic [3:0] pend;
        {req_commit, req_rewind, req_load, req_save} = m;
        pend = m; k = 0;
        r_ack_cyc = '{-1, -1, -1, -1}; r_done_cyc = -1; r_err = 1'b0; r_busy = 1'b0;
        while (k < 600 && (pend != 0 || busy)) begin
            @(posedge Clk); #1; k++;
            if (ack_commit) begin r_ack_cyc[0] = k; req_commit = 1'b0; pend[3] = 1'b0; end
            if (ack_rewind) begin r_ack_cyc[1] = k; req_rewind = 1'b0; pend[2] = 1'b0; end
            if (ack_load)   begin r_ack_cyc[2] = k; req_load   = 1'b0; pend[1] = 1'b0; end
            if (ack_save)   begin r_ack_cyc[3] = k; req_save   = 1'b0; pend[0] = 1'b0; end
            if (err) r_err = 1'b1;
            if (busy) r_busy = 1'b1;
            if (done) r_done_cyc = k;
        end
        if (pend != 0 || busy) begin
            tests++; fails++;
            $display("FAIL run_reqs_timeout: pending %b busy %0b after %0d cycles, required idle", pend, busy, k);
            {req_commit, req_rewind, req_load, req_save} = 4'b0000;
        end
        @(posedge Clk); #1;
    endtask

    logic [255:0] pat, pats [17];
    int n0;

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hist_count", hist_count, 0);
        check("rst_save_valid", save_valid, 0);
        check("rst_addrs", {brd_addr, hist_addr}, 0);
        reset_n = 1'b1;
        @(posedge Clk); #1;

        // 1: single commit of the i[3:0] pattern
        for (int i = 0; i < 64; i++) pat[i*4 +: 4] = 4'(i);
        load_board(pat);
        n0 = n_hist_wr;
        run_reqs(4'b1000);
        check("t1_ack_cycle", r_ack_cyc[0], 1);
        check("t1_done_cycle", r_done_cyc, 66);
        check("t1_hist_count", hist_count, 1);
        check("t1_slot0", hist_snap(1'b0, 0), pat);
        check("t1_hist_writes", n_hist_wr - n0, 64);

        // 2: clobber board, rewind restores it
        load_board({64{4'hF}});
        run_reqs(4'b0100);
        check("t2_board", brd_snap(), pat);
        check("t2_hist_count", hist_count, 0);

        // 3: refusals
        n0 = n_brd_wr + n_hist_wr;
        run_reqs(4'b0100);
        check("t3_rewind_ack_cycle", r_ack_cyc[1], 1);
        check("t3_rewind_err", r_err, 1);
        check("t3_rewind_busy", r_busy, 0);
        run_reqs(4'b0010);
        check("t3_load_ack_cycle", r_ack_cyc[2], 1);
        check("t3_load_err", r_err, 1);
        check("t3_load_busy", r_busy, 0);
        check("t3_no_writes", n_brd_wr + n_hist_wr - n0, 0);

        // 4: ring overflow then full unwind
        for (int j = 0; j < 17; j++) begin
            pats[j] = rand_pat();
            load_board(pats[j]);
            run_reqs(4'b1000);
        end
        check("t4_hist_count_full", hist_count, 16);
        for (int j = 0; j < 16; j++) begin
            run_reqs(4'b0100);
            check("t4_rewind_board", brd_snap(), pats[16-j]);
        end
        run_reqs(4'b0100);
        check("t4_17th_rewind_err", r_err, 1);

        // 5: simultaneous commit + rewind + save
        pat = rand_pat();
        load_board(pat);
        run_reqs(4'b1101);
        check("t5_commit_ack", r_ack_cyc[0], 1);
        check("t5_rewind_ack", r_ack_cyc[1], 67);
        check("t5_save_ack", r_ack_cyc[3], 133);
        check("t5_board", brd_snap(), pat);
        check("t5_save_slot", hist_snap(1'b1, 0), pat);

        // 6: reset in the middle of a commit
        pat = rand_pat();
        load_board(pat);
        req_commit = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge Clk); #1;
            if (ack_commit) req_commit = 1'b0;
        end
        check("t6_busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t6_busy_acks_strobes", {busy, ack_commit, brd_wr_en, hist_wr_en}, 0);
        check("t6_hist_count", hist_count, 0);
        check("t6_save_valid", save_valid, 0);
        repeat (2) @(posedge Clk);
        #1;
        reset_n = 1'b1;
        @(posedge Clk); #1;
        n0 = n_hist_wr;
        run_reqs(4'b0001);
        check("t6_save_valid_after", save_valid, 1);
        check("t6_save_slot", hist_snap(1'b1, 0), pat);
        check("t6_save_writes", n_hist_wr - n0, 64);

        // randomized request mixes
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) load_board(rand_pat());
            run_reqs(4'($urandom_range(1, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
